fast_subtractor: RTL and testbench
==================================

Name: fast_subtractor

Overview:
- 32-bit two's-complement subtractor computing S = A - B as A + ~B + 1.
- Uses a carry-lookahead structure (fast carry), not ripple carry.
- Provides a carry-out (no-borrow) flag and a signed-overflow flag.
- Used by the ALU comparator: carry-out drives GE (unsigned A >= B); results are registered.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of 4; only 32 is verified.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- S  output  WIDTH  registered difference A - B, modulo 2^WIDTH.
- C  output  1  registered carry-out of A + ~B + 1. 1 means no borrow, i.e. unsigned A >= B.
- V  output  1  registered signed overflow of A - B.

Behaviour:
- Datapath:
  - Bi = ~B[i]; carry-in c0 = 1.
  - Per bit: generate Gi = A[i] & Bi, propagate Pi = A[i] | Bi.
  - Bits are grouped in 4-bit lookahead blocks. Each block forms a group generate and group propagate.
  - A second-level lookahead unit over the 8 groups produces the group carry-ins. No carry ripples across more than one 4-bit block.
  - Sum bit: S[i] = A[i] ^ Bi ^ c[i].
  - C = c[WIDTH] (carry out of the MSB).
  - V = (A[MSB] ^ B[MSB]) & (S_comb[MSB] ^ A[MSB]).
- Timing:
  - The combinational result is captured into the S/C/V registers on every rising clk edge.
  - Latency is exactly 1 cycle: inputs present before edge N appear on the outputs after edge N.
  - Throughput: one operation per cycle.
  - No handshake and no enable; a new operand pair may be applied every cycle.
- Reset:
  - When rst = 1 at a rising edge, S = 0, C = 0 and V = 0, regardless of A and B.
  - Reset takes priority over the data capture.
  - On the first edge with rst = 0, outputs hold the result of the A and B present at that edge.
  - Asserting reset mid-stream discards the in-flight result.
- Boundary conditions:
  - A = B gives S = 0, C = 1, V = 0.
  - B = 0 gives S = A, C = 1, V = 0.
  - A = 0 with B != 0 gives C = 0 (borrow).
  - Wrap-around is modulo 2^WIDTH; no saturation.
- No X/Z propagation from internal nodes: every output bit is driven.
- Purely synthesizable. No delays in the RTL (gate-delay annotations are permitted only in simulation models).

Test Plan:
- Reset: hold rst = 1 with A = 0xFFFFFFFF, B = 0x1 -> after the edge S = 0, C = 0, V = 0. Release rst -> next edge S = 0xFFFFFFFE, C = 1, V = 0.
- Basic and borrow:
  - A = 5, B = 3 -> S = 0x00000002, C = 1, V = 0 one cycle later.
  - A = 3, B = 5 -> S = 0xFFFFFFFE, C = 0, V = 0.
- Equality and full carry chain: A = B = 0xA5A5A5A5 -> S = 0, C = 1, V = 0. A = 0, B = 0 -> S = 0, C = 1.
- Overflow:
  - A = 0x80000000, B = 0x00000001 -> S = 0x7FFFFFFF, C = 1, V = 1.
  - A = 0x7FFFFFFF, B = 0xFFFFFFFF -> S = 0x80000000, C = 0, V = 1.
- Full-length borrow propagation: A = 0x00000000, B = 0x00000001 -> S = 0xFFFFFFFF, C = 0, V = 0. Back-to-back with A = 0xFFFFFFFF, B = 0xFFFFFFFF on the next cycle -> S = 0, C = 1, confirming per-cycle pipelining.
- Random: 10,000 random A/B pairs (with a mid-stream reset pulse) compared against the reference model {C,S} = A + ~B + 1 and the V formula with 1-cycle latency. The output cycle following the reset pulse must read 0/0/0.

Source files
------------

// File: rtl/fast_subtractor.sv
// fast_subtractor
//   Registered two's-complement subtractor, S = A - B, formed as A + ~B + 1
//   with a two-level carry-lookahead adder (4-bit groups, lookahead across
//   groups), so no carry ripples through more than one 4-bit block.
//
// Ports
//   clk : clock, all registers update on the rising edge
//   rst : synchronous active-high reset, clears S/C/V
//   A   : minuend   [WIDTH-1:0]
//   B   : subtrahend [WIDTH-1:0]
//   S   : registered difference modulo 2^WIDTH
//   C   : registered carry-out (1 = no borrow, unsigned A >= B)
//   V   : registered signed overflow of A - B
module fast_subtractor #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] S,
   output logic             C,
   output logic             V
);

   localparam int NG = WIDTH / 4;

   logic [WIDTH-1:0] b_n;
   logic [WIDTH-1:0] g;
   logic [WIDTH-1:0] p;
   logic [NG-1:0]    grp_g;
   logic [NG-1:0]    grp_p;
   logic [NG:0]      grp_c;
   logic [WIDTH:0]   c;

   logic [WIDTH-1:0] s_d, s_q;
   logic             c_d, c_q;
   logic             v_d, v_q;

   // Per-bit generate/propagate and 4-bit group generate/propagate.
   always_comb begin
      b_n = ~B;
      g   = A & b_n;
      p   = A | b_n;
      grp_g = '0;
      grp_p = '0;
      for (int unsigned k = 0; k < NG; k++) begin
         grp_g[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      end
   end

   // Second-level lookahead: each group carry-in is the flattened sum of
   // products over all lower groups plus the carry-in of 1, rather than a
   // chain through the neighbouring group.
   always_comb begin
      logic term;
      grp_c = '0;
      for (int unsigned k = 0; k <= NG; k++) begin
         // carry-in of 1 propagated through groups 0..k-1
         term = 1'b1;
         for (int unsigned m = 0; m < k; m++) begin
            term = term & grp_p[m];
         end
         grp_c[k] = term;
         // group j generates, groups j+1..k-1 propagate
         for (int unsigned j = 0; j < k; j++) begin
            term = grp_g[j];
            for (int unsigned m = j + 1; m < k; m++) begin
               term = term & grp_p[m];
            end
            grp_c[k] = grp_c[k] | term;
         end
      end
   end

   // Bit carries inside each group come straight from the group carry-in.
   always_comb begin
      c = '0;
      for (int unsigned k = 0; k < NG; k++) begin
         c[4*k]   = grp_c[k];
         c[4*k+1] = g[4*k] | (p[4*k] & grp_c[k]);
         c[4*k+2] = g[4*k+1]
                  | (p[4*k+1] & g[4*k])
                  | (p[4*k+1] & p[4*k] & grp_c[k]);
         c[4*k+3] = g[4*k+2]
                  | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
      end
      c[WIDTH] = grp_c[NG];
   end

   always_comb begin
      s_d = A ^ b_n ^ c[WIDTH-1:0];
      c_d = c[WIDTH];
      v_d = (A[WIDTH-1] ^ B[WIDTH-1]) & (s_d[WIDTH-1] ^ A[WIDTH-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q <= '0;
         c_q <= 1'b0;
         v_q <= 1'b0;
      end else begin
         s_q <= s_d;
         c_q <= c_d;
         v_q <= v_d;
      end
   end

   assign S = s_q;
   assign C = c_q;
   assign V = v_q;

endmodule

// File: tb/tb_fast_subtractor.sv
// tb_fast_subtractor
//   Self-checking bench for fast_subtractor: directed vectors with literal
//   expectations plus an arithmetic reference model checked every cycle.
module tb_fast_subtractor;

   logic        clk;
   logic        rst;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] S;
   logic        C;
   logic        V;

   int checks   = 0;
   int failures = 0;
   logic chk_en = 1'b0;

   logic [31:0] exp_s;
   logic        exp_c;
   logic        exp_v;

   fast_subtractor #(.WIDTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .A  (A),
      .B  (B),
      .S  (S),
      .C  (C),
      .V  (V)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: unsigned compare for C, wide signed difference for V.
   always @(posedge clk) begin
      longint diff;
      if (rst) begin
         exp_s = '0;
         exp_c = 1'b0;
         exp_v = 1'b0;
      end else begin
         diff  = longint'($signed(A)) - longint'($signed(B));
         exp_s = A - B;
         exp_c = (A >= B);
         exp_v = (diff > 64'sd2147483647) || (diff < -64'sd2147483648);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_S", S, exp_s);
         chk("model_C", {31'b0, C}, {31'b0, exp_c});
         chk("model_V", {31'b0, V}, {31'b0, exp_v});
      end
   end

   task automatic apply(input string name, input logic r, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] es,
                        input logic ec, input logic ev);
      @(negedge clk);
      rst = r;
      A   = a;
      B   = b;
      @(posedge clk);
      #1;
      chk({name, "_S"}, S, es);
      chk({name, "_C"}, {31'b0, C}, {31'b0, ec});
      chk({name, "_V"}, {31'b0, V}, {31'b0, ev});
      chk({name, "_model"}, {exp_s[30:0], exp_c}, {es[30:0], ec});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      A   = '0;
      B   = '0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      apply("reset",     1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0);
      apply("release",   1'b0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0);
      apply("basic",     1'b0, 32'd5,        32'd3,        32'h00000002, 1'b1, 1'b0);
      apply("borrow",    1'b0, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 1'b0);
      apply("equal",     1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 1'b1, 1'b0);
      apply("zeros",     1'b0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0);
      apply("ovf_neg",   1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1);
      apply("ovf_pos",   1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1);
      apply("b_zero",    1'b0, 32'h12345678, 32'h00000000, 32'h12345678, 1'b1, 1'b0);
      apply("full_brw",  1'b0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0);
      apply("b2b_eq",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
      apply("a_zero",    1'b0, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1);
      apply("mid_rst",   1'b1, 32'h00000000, 32'h00000001, 32'h00000000, 1'b0, 1'b0);

      // Random stream, one operand pair per cycle, with a reset pulse.
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         A   = $urandom;
         B   = (i % 16 == 3) ? A : $urandom;
         rst = (i == 5000);
         if (i == 5001) begin
            chk("rst_pulse_S", S, 32'h0);
            chk("rst_pulse_C", {31'b0, C}, 32'h0);
            chk("rst_pulse_V", {31'b0, V}, 32'h0);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
